cgra_sram_arbiter: RTL and testbench

- Shares one CGRA SRAM bank (single-port, 1-cycle read latency, active-high set_retentive control) between NUM_PORTS requesters using round-robin arbitration.
- Each requester port is OBI-like: req/gnt/rvalid.
- Also sequences bank retention: after a programmable idle period the bank enters retentive mode; it is woken with a fixed guard interval before any access is granted.
- Sits between the CGRA/bus request ports and the bank wrapper instance.

---
 rtl/cgra_sram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cgra_sram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_sram_arbiter.sv
// Round-robin arbiter sharing one CGRA SRAM bank between OBI-like ports.
// Also sequences bank retention entry/exit around idle periods.
module cgra_sram_arbiter #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned AddrWidth   =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           ret_en_i,
  input  logic [NUM_PORTS-1:0]           req_i,
  input  logic [NUM_PORTS-1:0]           we_i,
  input  logic [NUM_PORTS*AddrWidth-1:0] addr_i,
  input  logic [NUM_PORTS*32-1:0]        wdata_i,
  input  logic [NUM_PORTS*4-1:0]         be_i,
  output logic [NUM_PORTS-1:0]           gnt_o,
  output logic [NUM_PORTS-1:0]           rvalid_o,
  output logic [NUM_PORTS*32-1:0]        rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  output logic [3:0]                     mem_be_o,
  output logic                           mem_set_retentive_o,
  input  logic [31:0]                    mem_rdata_i,
  output logic                           retentive_o
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WW = $clog2(WAKE_CYCLES + 1);

  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_CYCLES);
  localparam logic [PW-1:0] LAST_P   = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_RETENTIVE,
    ST_WAKE
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        w_ptr_nxt;
  logic [IW-1:0]        r_idle;
  logic [IW-1:0]        w_idle_nxt;
  logic [WW-1:0]        r_wake;
  logic [WW-1:0]        w_wake_nxt;
  logic                 r_set_ret;
  logic                 w_set_ret_nxt;
  logic [NUM_PORTS-1:0] r_rvalid;

  logic                 w_any;
  logic                 w_found;
  logic [PW-1:0]        w_win;
  logic                 w_gnt_vld;

  assign w_any = |req_i;

  // First requester at or after the pointer, wrapping to port 0.
  always_comb begin : arb
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      j = int'(r_ptr) + i;
      if (j >= int'(NUM_PORTS)) begin
        j = j - int'(NUM_PORTS);
      end
      if (!w_found && req_i[PW'(j)]) begin
        w_found = 1'b1;
        w_win   = PW'(j);
      end
    end
  end

  // Grants only in ACTIVE and never while reset is asserted.
  assign w_gnt_vld = rst_ni && (r_state == ST_ACTIVE) && w_found;

  assign w_ptr_nxt = (w_win == LAST_P) ? '0 : w_win + PW'(1);

  // Drive the bank from the winning port (port 0 when idle).
  always_comb begin
    gnt_o       = '0;
    mem_req_o   = w_gnt_vld;
    mem_we_o    = we_i[w_win];
    mem_addr_o  = addr_i[int'(w_win)*AddrWidth +: AddrWidth];
    mem_wdata_o = wdata_i[int'(w_win)*32 +: 32];
    mem_be_o    = be_i[int'(w_win)*4 +: 4];
    if (w_gnt_vld) begin
      gnt_o[w_win] = 1'b1;
    end
  end

  // Next-state logic for the retention sequencer and its counters.
  always_comb begin
    w_state_nxt   = r_state;
    w_idle_nxt    = '0;
    w_wake_nxt    = r_wake;
    w_set_ret_nxt = r_set_ret;
    unique case (r_state)
      ST_ACTIVE: begin
        if (w_any || !ret_en_i) begin
          w_idle_nxt = '0;
        end else if (r_idle == IDLE_MAX) begin
          w_idle_nxt = r_idle;
        end else begin
          w_idle_nxt = r_idle + IW'(1);
        end
        if ((w_idle_nxt == IDLE_MAX) && (r_rvalid == '0)) begin
          w_state_nxt   = ST_RETENTIVE;
          w_set_ret_nxt = 1'b1;
          w_idle_nxt    = '0;
        end
      end
      ST_RETENTIVE: begin
        if (w_any || !ret_en_i) begin
          w_state_nxt   = ST_WAKE;
          w_set_ret_nxt = 1'b0;
          w_wake_nxt    = WAKE_MAX;
        end
      end
      ST_WAKE: begin
        if (r_wake <= WW'(1)) begin
          w_state_nxt = ST_ACTIVE;
          w_wake_nxt  = '0;
        end else begin
          w_wake_nxt = r_wake - WW'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_ACTIVE;
        w_set_ret_nxt = 1'b0;
        w_wake_nxt    = '0;
      end
    endcase
  end

  // Sequencer state, counters and the registered retention control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_ACTIVE;
      r_idle    <= '0;
      r_wake    <= '0;
      r_set_ret <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idle    <= w_idle_nxt;
      r_wake    <= w_wake_nxt;
      r_set_ret <= w_set_ret_nxt;
    end
  end

  // Round-robin pointer and one-cycle-delayed response valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= gnt_o;
      if (w_gnt_vld) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign rvalid_o            = r_rvalid;
  assign rdata_o             = {NUM_PORTS{mem_rdata_i}};
  assign mem_set_retentive_o = r_set_ret;
  assign retentive_o         = (r_state != ST_ACTIVE);

endmodule

// File: tb/tb_cgra_sram_arbiter.sv
// Directed bench for cgra_sram_arbiter with a behavioural bank model.
// Expected responses are queued when requests are driven.
module tb_cgra_sram_arbiter;

  logic        clk;
  logic        rst_ni;
  logic        ret_en_i;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [19:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [63:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_set_retentive_o;
  logic [31:0] mem_rdata_i;
  logic        retentive_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  rv;
    logic        rd;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];

  logic [31:0] bank [0:1023];

  cgra_sram_arbiter dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .ret_en_i            (ret_en_i),
    .req_i               (req_i),
    .we_i                (we_i),
    .addr_i              (addr_i),
    .wdata_i             (wdata_i),
    .be_i                (be_i),
    .gnt_o               (gnt_o),
    .rvalid_o            (rvalid_o),
    .rdata_o             (rdata_o),
    .mem_req_o           (mem_req_o),
    .mem_we_o            (mem_we_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_be_o            (mem_be_o),
    .mem_set_retentive_o (mem_set_retentive_o),
    .mem_rdata_i         (mem_rdata_i),
    .retentive_o         (retentive_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port bank, one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) begin
            bank[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
          end
        end
      end else begin
        mem_rdata_i <= bank[mem_addr_o];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setp(input int p, input logic r, input logic w,
                      input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] b);
    req_i[p]            = r;
    we_i[p]             = w;
    addr_i[10*p +: 10]  = a;
    wdata_i[32*p +: 32] = d;
    be_i[4*p +: 4]      = b;
  endtask

  // Check grant for the inputs just driven and queue the response.
  task automatic exp_gnt(input int p, input logic rd,
                         input logic [31:0] d);
    logic [1:0] oh;
    exp_t e;
    #1;
    oh = 2'b00;
    if (p >= 0) oh[p] = 1'b1;
    chk("gnt", 32'(gnt_o), 32'(oh));
    chk("mem_req", 32'(mem_req_o), 32'(p >= 0));
    e.rv = oh;
    e.rd = rd;
    e.d  = d;
    sb.push_back(e);
  endtask

  // Advance one cycle and check the queued response.
  task automatic nxt();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rvalid", 32'(rvalid_o), 32'(e.rv));
      if (e.rd) begin
        chk("rdata0", rdata_o[31:0], e.d);
        chk("rdata1", rdata_o[63:32], e.d);
      end
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_setret", 32'(mem_set_retentive_o), 32'd0);
    chk("rst_ret", 32'(retentive_o), 32'd0);
    #1;
    rst_ni = 1'b1;
    sb.delete();
  endtask

  task automatic idle_run();
    for (int n = 0; n < 63; n++) begin
      nxt();
      chk("idle_setret", 32'(mem_set_retentive_o), 32'd0);
      chk("idle_ret", 32'(retentive_o), 32'd0);
    end
  endtask

  initial begin
    rst_ni   = 1'b0;
    ret_en_i = 1'b1;
    req_i    = 2'b11;
    we_i     = '0;
    addr_i   = '0;
    wdata_i  = '0;
    be_i     = '0;
    #2;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_setret", 32'(mem_set_retentive_o), 32'd0);
    chk("rst_ret", 32'(retentive_o), 32'd0);
    req_i  = 2'b00;
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Port 0 write / read, then a partial write and read back.
    setp(0, 1, 1, 10'h010, 32'hDEADBEEF, 4'hF);
    exp_gnt(0, 0, 0);
    chk("a_we", 32'(mem_we_o), 32'd1);
    chk("a_addr", 32'(mem_addr_o), 32'h010);
    chk("a_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("a_be", 32'(mem_be_o), 32'hF);
    nxt();
    setp(0, 1, 0, 10'h010, 32'h0, 4'hF);
    exp_gnt(0, 1, 32'hDEADBEEF);
    chk("a_rd_we", 32'(mem_we_o), 32'd0);
    nxt();
    setp(0, 1, 1, 10'h010, 32'h00001111, 4'h3);
    exp_gnt(0, 0, 0);
    chk("a_be2", 32'(mem_be_o), 32'h3);
    nxt();
    setp(0, 1, 0, 10'h010, 32'h0, 4'hF);
    exp_gnt(0, 1, 32'hDEAD1111);
    nxt();
    setp(0, 0, 0, 10'h000, 32'h0, 4'h0);
    exp_gnt(-1, 0, 0);
    nxt();

    // Two ports contending from reset: strict alternation.
    do_reset();
    setp(0, 1, 1, 10'h020, 32'hA0A0A0A0, 4'hF);
    setp(1, 1, 1, 10'h3FF, 32'h12345678, 4'hF);
    for (int k = 0; k < 4; k++) begin
      exp_gnt(k % 2, 0, 0);
      chk("b_addr", 32'(mem_addr_o),
          (k % 2 == 0) ? 32'h020 : 32'h3FF);
      nxt();
    end
    setp(0, 0, 0, 10'h000, 32'h0, 4'h0);
    setp(1, 0, 0, 10'h000, 32'h0, 4'h0);
    exp_gnt(-1, 0, 0);

    // Idle run into retention.
    idle_run();
    nxt();
    chk("c_setret", 32'(mem_set_retentive_o), 32'd1);
    chk("c_ret", 32'(retentive_o), 32'd1);

    // Wake on a port 1 read: grant three cycles after req rises.
    setp(1, 1, 0, 10'h3FF, 32'h0, 4'hF);
    exp_gnt(-1, 0, 0);
    nxt();
    chk("d_setret", 32'(mem_set_retentive_o), 32'd0);
    chk("d_wake1", 32'(retentive_o), 32'd1);
    exp_gnt(-1, 0, 0);
    nxt();
    chk("d_wake2", 32'(retentive_o), 32'd1);
    exp_gnt(-1, 0, 0);
    nxt();
    chk("d_active", 32'(retentive_o), 32'd0);
    exp_gnt(1, 1, 32'h12345678);
    chk("d_addr", 32'(mem_addr_o), 32'h3FF);
    nxt();
    setp(1, 0, 0, 10'h000, 32'h0, 4'h0);
    exp_gnt(-1, 0, 0);

    // Request on the very cycle the idle count completes.
    idle_run();
    setp(0, 1, 1, 10'h030, 32'h55AA55AA, 4'hF);
    exp_gnt(0, 0, 0);
    nxt();
    chk("e_setret", 32'(mem_set_retentive_o), 32'd0);
    chk("e_ret", 32'(retentive_o), 32'd0);
    setp(0, 0, 0, 10'h000, 32'h0, 4'h0);
    exp_gnt(-1, 0, 0);
    idle_run();
    nxt();
    chk("e_setret2", 32'(mem_set_retentive_o), 32'd1);

    // Reset during WAKE, then during an access.
    setp(0, 1, 0, 10'h010, 32'h0, 4'hF);
    exp_gnt(-1, 0, 0);
    nxt();
    chk("f_wake", 32'(retentive_o), 32'd1);
    do_reset();
    exp_gnt(0, 1, 32'hDEAD1111);
    nxt();
    exp_gnt(0, 1, 32'hDEAD1111);
    do_reset();
    setp(0, 0, 0, 10'h000, 32'h0, 4'h0);
    exp_gnt(-1, 0, 0);
    nxt();
    chk("f_ret", 32'(retentive_o), 32'd0);

    // Retention disabled keeps the bank awake.
    ret_en_i = 1'b0;
    repeat (70) nxt();
    chk("g_setret", 32'(mem_set_retentive_o), 32'd0);
    chk("g_ret", 32'(retentive_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
